// File: rtl/battle_hp_tracker.sv
// Fight bookkeeping: applies edge-detected damage events to both fighters,
// runs the idle/fight/result sequence and keeps saturating win tallies.
module battle_hp_tracker #(
  parameter int MAX_HP    = 100,
  parameter int WIN_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           dmg_p,
  input  logic                 dmg_p_en,
  input  logic [7:0]           dmg_e,
  input  logic                 dmg_e_en,
  output logic [7:0]           hp_player,
  output logic [7:0]           hp_enemy,
  output logic                 battle_active,
  output logic                 player_win,
  output logic                 enemy_win,
  output logic                 draw,
  output logic                 hit_p,
  output logic                 hit_e,
  output logic                 miss_p,
  output logic                 miss_e,
  output logic [WIN_CNT_W-1:0] p_wins,
  output logic [WIN_CNT_W-1:0] e_wins
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIGHT = 3'd1,
    P_WIN = 3'd2,
    E_WIN = 3'd3,
    DRAW  = 3'd4
  } state_t;

  localparam logic [7:0]           HP_INIT = 8'(MAX_HP);
  localparam logic [WIN_CNT_W-1:0] WIN_MAX = '1;

  state_t     state;
  logic       en_q_p;
  logic       en_q_e;
  logic       ev_p;
  logic       ev_e;
  logic [7:0] hp_p_new;
  logic [7:0] hp_e_new;

  assign ev_p = dmg_p_en & ~en_q_p;
  assign ev_e = dmg_e_en & ~en_q_e;

  // Saturating hit-point update; only meaningful while fighting.
  always_comb begin
    hp_p_new = hp_player;
    hp_e_new = hp_enemy;
    if (ev_p) begin
      hp_p_new = (dmg_p >= hp_player) ? 8'd0 : hp_player - dmg_p;
    end
    if (ev_e) begin
      hp_e_new = (dmg_e >= hp_enemy) ? 8'd0 : hp_enemy - dmg_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      en_q_p        <= 1'b0;
      en_q_e        <= 1'b0;
      hp_player     <= HP_INIT;
      hp_enemy      <= HP_INIT;
      battle_active <= 1'b0;
      player_win    <= 1'b0;
      enemy_win     <= 1'b0;
      draw          <= 1'b0;
      hit_p         <= 1'b0;
      hit_e         <= 1'b0;
      miss_p        <= 1'b0;
      miss_e        <= 1'b0;
      p_wins        <= '0;
      e_wins        <= '0;
    end else begin
      en_q_p <= dmg_p_en;
      en_q_e <= dmg_e_en;
      hit_p  <= 1'b0;
      hit_e  <= 1'b0;
      miss_p <= 1'b0;
      miss_e <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state         <= FIGHT;
            hp_player     <= HP_INIT;
            hp_enemy      <= HP_INIT;
            battle_active <= 1'b1;
          end
        end

        FIGHT: begin
          // A restart wins over any damage arriving on the same edge.
          if (start) begin
            hp_player <= HP_INIT;
            hp_enemy  <= HP_INIT;
          end else begin
            hp_player <= hp_p_new;
            hp_enemy  <= hp_e_new;
            hit_p     <= ev_p && (dmg_p != 8'd0);
            miss_p    <= ev_p && (dmg_p == 8'd0);
            hit_e     <= ev_e && (dmg_e != 8'd0);
            miss_e    <= ev_e && (dmg_e == 8'd0);
            if (hp_p_new == 8'd0 && hp_e_new == 8'd0) begin
              state         <= DRAW;
              battle_active <= 1'b0;
              draw          <= 1'b1;
            end else if (hp_e_new == 8'd0) begin
              state         <= P_WIN;
              battle_active <= 1'b0;
              player_win    <= 1'b1;
              if (p_wins != WIN_MAX) p_wins <= p_wins + 1'b1;
            end else if (hp_p_new == 8'd0) begin
              state         <= E_WIN;
              battle_active <= 1'b0;
              enemy_win     <= 1'b1;
              if (e_wins != WIN_MAX) e_wins <= e_wins + 1'b1;
            end
          end
        end

        P_WIN, E_WIN, DRAW: begin
          if (start) begin
            state         <= FIGHT;
            hp_player     <= HP_INIT;
            hp_enemy      <= HP_INIT;
            battle_active <= 1'b1;
            player_win    <= 1'b0;
            enemy_win     <= 1'b0;
            draw          <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          battle_active <= 1'b0;
          player_win    <= 1'b0;
          enemy_win     <= 1'b0;
          draw          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_battle_hp_tracker.sv
// Bench for battle_hp_tracker: directed scenarios followed by random traffic,
// every cycle compared against an arithmetic model of the fight rules.
module tb_battle_hp_tracker;

  localparam int MAX_HP    = 100;
  localparam int WIN_CNT_W = 4;
  localparam int TALLY_MAX = (1 << WIN_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [7:0]           dmg_p = '0;
  logic                 dmg_p_en = 1'b0;
  logic [7:0]           dmg_e = '0;
  logic                 dmg_e_en = 1'b0;
  logic [7:0]           hp_player, hp_enemy;
  logic                 battle_active, player_win, enemy_win, draw;
  logic                 hit_p, hit_e, miss_p, miss_e;
  logic [WIN_CNT_W-1:0] p_wins, e_wins;

  battle_hp_tracker #(.MAX_HP(MAX_HP), .WIN_CNT_W(WIN_CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dmg_p(dmg_p), .dmg_p_en(dmg_p_en), .dmg_e(dmg_e), .dmg_e_en(dmg_e_en),
    .hp_player(hp_player), .hp_enemy(hp_enemy),
    .battle_active(battle_active), .player_win(player_win),
    .enemy_win(enemy_win), .draw(draw),
    .hit_p(hit_p), .hit_e(hit_e), .miss_p(miss_p), .miss_e(miss_e),
    .p_wins(p_wins), .e_wins(e_wins)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: fighting / outcome flags plus plain integer hit points.
  bit m_fighting, m_pwin, m_ewin, m_draw;
  int m_hp_p, m_hp_e, m_pw, m_ew;
  bit m_prev_p, m_prev_e;
  bit m_hit_p, m_hit_e, m_miss_p, m_miss_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, s, input int dp, input bit pe,
                            input int de, input bit ee);
    bit evp, eve;
    if (r) begin
      m_fighting = 0; m_pwin = 0; m_ewin = 0; m_draw = 0;
      m_hp_p = MAX_HP; m_hp_e = MAX_HP; m_pw = 0; m_ew = 0;
      m_prev_p = 0; m_prev_e = 0;
      m_hit_p = 0; m_hit_e = 0; m_miss_p = 0; m_miss_e = 0;
      return;
    end
    evp = pe && !m_prev_p;
    eve = ee && !m_prev_e;
    m_prev_p = pe;
    m_prev_e = ee;
    m_hit_p = 0; m_hit_e = 0; m_miss_p = 0; m_miss_e = 0;
    if (s) begin
      m_fighting = 1; m_pwin = 0; m_ewin = 0; m_draw = 0;
      m_hp_p = MAX_HP; m_hp_e = MAX_HP;
    end else if (m_fighting) begin
      if (evp) begin
        m_hp_p = (dp >= m_hp_p) ? 0 : m_hp_p - dp;
        m_hit_p = (dp != 0); m_miss_p = (dp == 0);
      end
      if (eve) begin
        m_hp_e = (de >= m_hp_e) ? 0 : m_hp_e - de;
        m_hit_e = (de != 0); m_miss_e = (de == 0);
      end
      if (m_hp_p == 0 || m_hp_e == 0) begin
        m_fighting = 0;
        if (m_hp_p == 0 && m_hp_e == 0) m_draw = 1;
        else if (m_hp_e == 0) begin
          m_pwin = 1;
          if (m_pw < TALLY_MAX) m_pw++;
        end else begin
          m_ewin = 1;
          if (m_ew < TALLY_MAX) m_ew++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("hp_player", 32'(hp_player), 32'(m_hp_p));
    chk("hp_enemy", 32'(hp_enemy), 32'(m_hp_e));
    chk("battle_active", 32'(battle_active), 32'(m_fighting));
    chk("player_win", 32'(player_win), 32'(m_pwin));
    chk("enemy_win", 32'(enemy_win), 32'(m_ewin));
    chk("draw", 32'(draw), 32'(m_draw));
    chk("hit_p", 32'(hit_p), 32'(m_hit_p));
    chk("hit_e", 32'(hit_e), 32'(m_hit_e));
    chk("miss_p", 32'(miss_p), 32'(m_miss_p));
    chk("miss_e", 32'(miss_e), 32'(m_miss_e));
    chk("p_wins", 32'(p_wins), 32'(m_pw));
    chk("e_wins", 32'(e_wins), 32'(m_ew));
  endtask

  task automatic step(input bit r, s, input int dp, input bit pe,
                      input int de, input bit ee);
    @(negedge clk);
    rst = r; start = s;
    dmg_p = 8'(dp); dmg_p_en = pe;
    dmg_e = 8'(de); dmg_e_en = ee;
    @(posedge clk);
    model_edge(r, s, dp, pe, de, ee);
    #1;
    check_all();
  endtask

  initial begin
    int hits;
    // Reset and idle behaviour
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_hp_p", 32'(hp_player), 100);
    chk("rst_hp_e", 32'(hp_enemy), 100);
    chk("rst_flags", {battle_active, player_win, enemy_win, draw}, 0);
    step(0, 0, 0, 0, 30, 1);
    step(0, 0, 0, 0, 30, 0);
    chk("idle_ignore", 32'(hp_enemy), 100);

    // Held enable gives one event
    step(0, 1, 0, 0, 0, 0);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 30, 1);
      if (hit_e) hits++;
      if (i == 0) chk("hold_first", 32'(hp_enemy), 70);
    end
    step(0, 0, 0, 0, 30, 0);
    chk("hold_hp", 32'(hp_enemy), 70);
    chk("hold_hits", 32'(hits), 1);

    // KO by enemy damage, then damage ignored in result
    step(0, 0, 0, 0, 50, 1);
    step(0, 0, 0, 0, 50, 0);
    chk("hp_e_20", 32'(hp_enemy), 20);
    step(0, 0, 0, 0, 35, 1);
    chk("ko_hit_e", 32'(hit_e), 1);
    chk("ko_win", {player_win, battle_active}, 2'b10);
    chk("ko_tally", 32'(p_wins), 1);
    step(0, 0, 0, 0, 35, 0);
    step(0, 0, 40, 1, 0, 0);
    step(0, 0, 40, 0, 0, 0);
    chk("result_frozen", 32'(hp_player), 100);

    // Simultaneous KO is a draw
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 90, 1, 90, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 12, 1, 12, 1);
    chk("draw_flag", 32'(draw), 1);
    chk("draw_tally", {28'd0, p_wins}, 1);
    step(0, 0, 0, 0, 0, 0);

    // Zero-damage miss
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("miss_hit", {miss_p, hit_p}, 2'b10);
    step(0, 0, 0, 0, 0, 0);
    chk("miss_once", 32'(miss_p), 0);

    // Tally saturation
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 255, 1);
      step(0, 0, 0, 0, 0, 0);
    end
    chk("p_wins_sat", 32'(p_wins), 15);

    // Restart discards a coincident event
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 25, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 60, 1, 0, 0);
    chk("restart_hp", 32'(hp_player), 100);
    chk("restart_nohit", 32'(hit_p), 0);
    step(0, 0, 60, 1, 0, 0);
    chk("restart_held", 32'(hp_player), 100);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int dp, de;
      dp = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 70);
      de = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 70);
      if ($urandom_range(0, 30) == 0) dp = 255;
      step($urandom_range(0, 400) == 0, $urandom_range(0, 25) == 0,
           dp, 1'($urandom_range(0, 1)), de, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
